// File: rtl/mem_wr_arbiter_if.sv
// Requester/memory write bus for mem_wr_arbiter.
// The master modport is the arbiter: it drives the memory write port and the per-requester ready.
interface mem_wr_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
);
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_lock;
    logic [N*8-1:0]     req_addr;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_ready;
    logic [7:0]         mem_addr;
    logic [WIDTH-1:0]   mem_data;
    logic               mem_write;

    modport master (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, mem_addr, mem_data, mem_write
    );

    modport slave (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, mem_addr, mem_data, mem_write
    );
endinterface

// File: rtl/mem_wr_arbiter.sv
// Round-robin arbiter sharing one memory write port among N requesters, with locked bursts.
// Define MEM_WR_ARB_STAT_EN to add per-requester saturating beat counters (stat_clr/stat_cnt).
module mem_wr_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arb_en,
`ifdef MEM_WR_ARB_STAT_EN
    input  logic                 stat_clr,
    output logic [N*16-1:0]      stat_cnt,
`endif
    output logic [$clog2(N)-1:0] cur_owner,
    mem_wr_arbiter_if.master     bus
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_reg;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   owner_reg;
    logic [PW-1:0]   cur_owner_reg;
    logic [CW-1:0]   cnt_reg;
    logic [7:0]      mem_addr_reg;
    logic [WIDTH-1:0] mem_data_reg;
    logic            mem_write_reg;

    logic [PW-1:0]   search_idx;
    logic            search_hit;
    logic [N-1:0]    ready_next;
    logic [PW-1:0]   acc_idx;
    logic            accept;

    // Scan from farthest to nearest so the nearest valid index after ptr wins.
    always_comb begin
        int idx;
        search_idx = '0;
        search_hit = 1'b0;
        idx        = 0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N) idx = idx - N;
            if (bus.req_valid[idx]) begin
                search_hit = 1'b1;
                search_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        ready_next = '0;
        acc_idx    = (state_reg == BURST) ? owner_reg : search_idx;
        if (reset_n && arb_en) begin
            if (state_reg == BURST) begin
                if (bus.req_valid[owner_reg]) ready_next[owner_reg] = 1'b1;
            end else if (search_hit) begin
                ready_next[search_idx] = 1'b1;
            end
        end
    end

    assign accept        = |(ready_next & bus.req_valid);
    assign bus.req_ready = ready_next;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_data  = mem_data_reg;
    assign bus.mem_write = mem_write_reg;
    assign cur_owner     = cur_owner_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= PW'(N - 1);
            owner_reg     <= '0;
            cur_owner_reg <= '0;
            cnt_reg       <= '0;
            mem_addr_reg  <= '0;
            mem_data_reg  <= '0;
            mem_write_reg <= 1'b0;
        end else begin
            mem_write_reg <= accept;
            if (accept) begin
                mem_addr_reg  <= bus.req_addr[int'(acc_idx)*8 +: 8];
                mem_data_reg  <= bus.req_data[int'(acc_idx)*WIDTH +: WIDTH];
                cur_owner_reg <= acc_idx;
            end
            if (arb_en) begin
                if (state_reg == IDLE) begin
                    if (accept) begin
                        ptr_reg <= acc_idx;
                        if (bus.req_lock[acc_idx] && (MAX_BURST > 1)) begin
                            state_reg <= BURST;
                            owner_reg <= acc_idx;
                            cnt_reg   <= CW'(1);
                        end
                    end
                end else begin
                    // ptr already points at the owner, so a release hands priority onward.
                    if (accept) begin
                        if (!bus.req_lock[owner_reg] || (cnt_reg + CW'(1) == CW'(MAX_BURST))) begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end else begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end
                end
            end
        end
    end

`ifdef MEM_WR_ARB_STAT_EN
    for (genvar gi = 0; gi < N; gi++) begin : g_stat
        logic [15:0] beat_cnt_reg;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                beat_cnt_reg <= '0;
            end else if (stat_clr) begin
                beat_cnt_reg <= '0;
            end else if (accept && (acc_idx == PW'(gi)) && (beat_cnt_reg != 16'hFFFF)) begin
                beat_cnt_reg <= beat_cnt_reg + 16'd1;
            end
        end
        assign stat_cnt[gi*16 +: 16] = beat_cnt_reg;
    end
`endif
endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Randomized and directed bench for mem_wr_arbiter against a transaction-level reference model.
module tb_mem_wr_arbiter;
    localparam int N         = 4;
    localparam int WIDTH     = 16;
    localparam int MAX_BURST = 8;

    logic       clk;
    logic       reset_n;
    logic       arb_en;
    logic [1:0] cur_owner;
`ifdef MEM_WR_ARB_STAT_EN
    logic          stat_clr;
    logic [N*16-1:0] stat_cnt;
    int            m_stat [N];
`endif

    mem_wr_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus();

    mem_wr_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .arb_en    (arb_en),
`ifdef MEM_WR_ARB_STAT_EN
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt),
`endif
        .cur_owner (cur_owner),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model: round-robin position, burst bookkeeping, expected outputs.
    int              m_ptr;
    bit              m_burst;
    int              m_owner;
    int              m_beats;
    logic            exp_write;
    logic [7:0]      exp_addr;
    logic [WIDTH-1:0] exp_data;
    int              exp_owner;
    int              last_g;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ptr     = N - 1;
        m_burst   = 0;
        m_owner   = 0;
        m_beats   = 0;
        exp_write = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_owner = 0;
`ifdef MEM_WR_ARB_STAT_EN
        for (int i = 0; i < N; i++) m_stat[i] = 0;
`endif
    endfunction

    function automatic int model_grant();
        int i;
        if (!reset_n || !arb_en) return -1;
        if (m_burst) return bus.req_valid[m_owner] ? m_owner : -1;
        for (int k = 1; k <= N; k++) begin
            i = (m_ptr + k) % N;
            if (bus.req_valid[i]) return i;
        end
        return -1;
    endfunction

    // Entered at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic step();
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", bus.req_ready, exp_rdy);
        @(posedge clk);
        #1;
        last_g = g;
        if (g >= 0) begin
            exp_write = 1'b1;
            exp_addr  = bus.req_addr[g*8 +: 8];
            exp_data  = bus.req_data[g*WIDTH +: WIDTH];
            exp_owner = g;
        end else begin
            exp_write = 1'b0;
        end
        if (arb_en) begin
            if (m_burst) begin
                if (g < 0) m_burst = 0;
                else begin
                    m_beats++;
                    if (!bus.req_lock[g] || m_beats >= MAX_BURST) m_burst = 0;
                end
            end else if (g >= 0) begin
                m_ptr = g;
                if (bus.req_lock[g] && MAX_BURST > 1) begin
                    m_burst = 1;
                    m_owner = g;
                    m_beats = 1;
                end
            end
        end
        check("mem_write", bus.mem_write, exp_write);
        check("mem_addr", bus.mem_addr, exp_addr);
        check("mem_data", bus.mem_data, exp_data);
        check("cur_owner", cur_owner, exp_owner);
`ifdef MEM_WR_ARB_STAT_EN
        if (stat_clr) begin
            for (int i = 0; i < N; i++) m_stat[i] = 0;
        end else if (g >= 0 && m_stat[g] < 65535) begin
            m_stat[g]++;
        end
        for (int i = 0; i < N; i++) check("stat_cnt", stat_cnt[i*16 +: 16], m_stat[i]);
`endif
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        arb_en        = 1'b1;
        bus.req_valid = '1;
        bus.req_lock  = '0;
        #2;
        check("rst_ready", bus.req_ready, 0);
        check("rst_write", bus.mem_write, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_data", bus.mem_data, 0);
        check("rst_owner", cur_owner, 0);
        bus.req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*8 +: 8]         = 8'($urandom);
            bus.req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
    endtask

    initial begin
        int q[$];
        int run;
        checks        = 0;
        failures      = 0;
        last_g        = -1;
        reset_n       = 1'b0;
        arb_en        = 1'b0;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
`ifdef MEM_WR_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        model_reset();
        #1;
        do_reset();

        // All valid, no lock: grants rotate 0,1,2,3,0.
        bus.req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            rand_payload();
            step();
            check("rr_order", last_g, c % N);
        end

        // Requester 2 locked: 8 consecutive beats then requester 3.
        do_reset();
        bus.req_valid = '1;
        bus.req_lock  = 4'b0100;
        q = {};
        for (int c = 0; c < 16; c++) begin
            rand_payload();
            step();
            q.push_back(last_g);
        end
        run = 0;
        while (q[2 + run] == 2 && run < 12) run++;
        check("burst_len", run, MAX_BURST);
        check("after_burst", q[2 + run], 3);

        // Requester 1 in burst drops valid for one cycle.
        do_reset();
        bus.req_valid = '1;
        bus.req_lock  = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            rand_payload();
            step();
        end
        bus.req_valid = 4'b1101;
        step();
        check("drop_nogrant", last_g, -1);
        bus.req_valid = '1;
        bus.req_lock  = '0;
        step();
        check("drop_next", last_g, 2);

        // arb_en low for 3 cycles mid-stream.
        do_reset();
        bus.req_valid = '1;
        step();
        step();
        arb_en = 1'b0;
        for (int c = 0; c < 3; c++) step();
        arb_en = 1'b1;
        step();
        check("en_resume", last_g, 2);

        // Asynchronous reset while a beat with addr 8'h5A is on the port.
        do_reset();
        bus.req_valid = '1;
        for (int i = 0; i < N; i++) bus.req_addr[i*8 +: 8] = 8'h5A;
        step();
        step();
        check("pre_rst_addr", bus.mem_addr, 8'h5A);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_write", bus.mem_write, 0);
        check("arst_addr", bus.mem_addr, 0);
        check("arst_owner", cur_owner, 0);
        check("arst_ready", bus.req_ready, 0);
        bus.req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        bus.req_valid = '1;
        step();
        check("arst_first", last_g, 0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            arb_en        = ($urandom_range(0, 9) != 0);
            bus.req_valid = 4'($urandom);
            bus.req_lock  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            rand_payload();
            step();
        end
        arb_en = 1'b1;

`ifdef MEM_WR_ARB_STAT_EN
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_lock  = '0;
        for (int c = 0; c < 5; c++) step();
        check("stat_five", stat_cnt[15:0], 5);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("stat_clr", stat_cnt[15:0], 0);
        for (int c = 0; c < 65540; c++) step();
        check("stat_sat", stat_cnt[15:0], 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_wr_arbiter.md
Name: mem_wr_arbiter

Overview:
- Shares one memory write port (addr 8 bit, data WIDTH, write strobe) between N requesters.
- Round-robin arbitration, with optional per-requester locked bursts.
- Registered output drives the master side of the memory write interface. It sits between producer blocks and the shared memory write port.
- The memory side has no backpressure; every accepted beat becomes exactly one mem_write pulse.

Parameters:
- N, 4, number of requesters; legal range 2..8.
- WIDTH, 16, data width; matches the memory write interface data width.
- MAX_BURST, 8, maximum beats one requester may hold in a locked burst; legal range 1..16.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- arb_en  input  1  arbitration enable; 0 = no new beats accepted.
- req_valid  input  N  requester i has a write pending.
- req_lock  input  N  requester i asks to keep the grant after this beat.
- req_addr  input  N*8  requester i address, slice [i*8+7:i*8].
- req_data  input  N*WIDTH  requester i data, slice [i*WIDTH+WIDTH-1:i*WIDTH].
- req_ready  output  N  combinational grant; a beat is accepted when req_valid[i] & req_ready[i].
- mem_addr  output  8  registered write address.
- mem_data  output  WIDTH  registered write data.
- mem_write  output  1  registered one-cycle write strobe.
- cur_owner  output  $clog2(N)  index of the last granted requester (debug).

Behaviour:
- Reset (async, reset_n=0):
  - mem_write=0, mem_addr=0, mem_data=0, req_ready=0, cur_owner=0.
  - State IDLE; rr pointer ptr=N-1, so requester 0 wins first; beat counter=0.
- At most one req_ready bit is high in any cycle. req_ready is all-zero when arb_en=0 or no requester in scope is valid.
- State IDLE:
  - Search req_valid from ptr+1 upward, modulo N; the first valid index i gets req_ready[i]=1.
  - On acceptance: ptr<=i, cur_owner<=i.
  - If req_lock[i]=1 and MAX_BURST>1: go to BURST with owner=i, beat counter=1. Otherwise stay in IDLE.
- State BURST:
  - Only the owner may receive ready; all other requesters see ready=0.
  - Owner accepted with req_lock=0: go to IDLE.
  - Owner accepted with counter+1==MAX_BURST: go to IDLE (forced release); ptr stays at owner, so other requesters win next.
  - Otherwise the counter increments and the state stays BURST.
  - Owner req_valid=0 for one cycle (with arb_en=1): release. Go to IDLE next cycle; no grant to anyone that cycle.
- arb_en=0: req_ready=0 and state, ptr and counter are frozen. An in-flight mem_write from the previous cycle still completes.
- Output timing:
  - Latency is 1 cycle. Accepted beat at cycle t gives mem_write=1 with that beat's addr/data at t+1.
  - mem_write=0 in any cycle after a non-accepting cycle; mem_addr/mem_data hold their last values.
  - Back-to-back accepted beats produce continuous mem_write=1, one beat per clock (full throughput).
- Widths: ptr, cur_owner and owner are $clog2(N) bits. Modulo wrap is explicit for non-power-of-2 N. Beat counter is $clog2(MAX_BURST)+1 bits.
- Reset mid-burst: immediate return to the reset state; a pending mem_write is dropped.

Optional Feature:
- Macro: MEM_WR_ARB_STAT_EN.
- Defined:
  - Adds input stat_clr (1 bit) and output stat_cnt (N*16 bits).
  - Each 16-bit slice counts accepted beats for its requester and saturates at 16'hFFFF.
  - stat_clr=1 synchronously zeroes all counters. A beat accepted in the same cycle as stat_clr is not counted.
  - Counters reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- After reset, all req_valid=4'b1111, lock=0, arb_en=1:
  - Grants rotate 0,1,2,3,0.
  - mem_write is high every cycle from cycle 1.
  - mem_addr sequence equals each requester's addr, one cycle after its grant.
- Requester 2 asserts lock=1 with valid held, MAX_BURST=8, others valid:
  - Exactly 8 consecutive beats from 2.
  - Forced release, then requester 3 granted.
- Requester 1 in a burst drops valid for one cycle:
  - No grant that cycle.
  - Next cycle the round-robin search starts from 2.
- arb_en=0 for 3 cycles mid-stream:
  - req_ready=0 and mem_write=0 after the in-flight beat.
  - ptr is unchanged; the sequence resumes with the same next requester.
- reset_n pulsed low asynchronously while mem_write=1 with addr 8'h5A:
  - Outputs go to 0 immediately.
  - The first grant after release goes to requester 0.
- With MEM_WR_ARB_STAT_EN defined:
  - 5 beats from requester 0 gives stat_cnt[15:0]=5.
  - stat_clr then gives 0.
  - A counter preloaded by 65540 beats reads 16'hFFFF.
